count_monitor: RTL and testbench

- Passive checker on the output side of the team's up-counter.
- Samples `count`, the counter's `enable` and the counter's own reset each clock, and predicts the next value.
- Reports whether the counter follows increment / hold / reset semantics, tracks lock, and counts errors.
- Sits beside the counter in benches and on-board self-test; it never drives the counter.

---
 rtl/count_monitor_pkg.sv | 14 +
 rtl/count_predictor.sv | 51 +++++
 rtl/count_monitor.sv | 104 ++++++++++
 tb/tb_count_monitor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: shared states and default sizes for the counter monitor
package count_monitor_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_LOCK_LEN = 4;
    localparam int DEF_ERR_W    = 8;
    localparam int WRAP_W       = 8;

    typedef enum logic {
        SYNC,
        LOCKED
    } state_t;

endpackage

// File: rtl/count_predictor.sv
// count_predictor: keeps one sample of counter history and predicts the next value (wrap_hit only with COUNT_MONITOR_WRAP_EN)
module count_predictor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dut_reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] expected,
    output logic             cmp_valid,
    output logic             match
`ifdef COUNT_MONITOR_WRAP_EN
    ,
    output logic             wrap_hit
`endif
);

    logic [WIDTH-1:0] prev;
    logic             prev_en;
    logic             prev_rst;
    logic             hist_valid;

    // history always follows the observed sample so resync starts from whatever was seen
    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= '0;
            prev_en    <= 1'b0;
            prev_rst   <= 1'b0;
            hist_valid <= 1'b0;
        end else begin
            prev       <= count;
            prev_en    <= enable;
            prev_rst   <= dut_reset;
            hist_valid <= 1'b1;
        end
    end

    // prediction is a pure function of the history flops; counter reset beats enable
    always_comb begin
        expected  = prev_rst ? '0 : prev_en ? prev + 1'b1 : prev;
        cmp_valid = hist_valid;
        match     = count == expected;
`ifdef COUNT_MONITOR_WRAP_EN
        wrap_hit  = match && prev_en && (prev == '1) && (count == '0);
`endif
    end

endmodule

// File: rtl/count_monitor.sv
// count_monitor: passive lock/mismatch checker for an up-counter; COUNT_MONITOR_WRAP_EN adds a wrap_count output
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_LEN = DEF_LOCK_LEN,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dut_reset,
    input  logic              enable,
    input  logic [WIDTH-1:0]  count,
    output logic              locked,
    output logic              mismatch,
    output logic [ERR_W-1:0]  err_count,
    output logic [WIDTH-1:0]  expected
`ifdef COUNT_MONITOR_WRAP_EN
    ,
    output logic [WRAP_W-1:0] wrap_count
`endif
);

    localparam int RUN_W = $clog2(LOCK_LEN + 1);

    state_t             state, state_n;
    logic [RUN_W-1:0]   run, run_n;
    logic               mismatch_n;
    logic [ERR_W-1:0]   err_n;
    logic               cmp_valid;
    logic               match;
`ifdef COUNT_MONITOR_WRAP_EN
    logic               wrap_hit;
`endif

    count_predictor #(
        .WIDTH(WIDTH)
    ) u_pred (
        .clk       (clk),
        .reset     (reset),
        .dut_reset (dut_reset),
        .enable    (enable),
        .count     (count),
        .expected  (expected),
        .cmp_valid (cmp_valid),
        .match     (match)
`ifdef COUNT_MONITOR_WRAP_EN
        ,
        .wrap_hit  (wrap_hit)
`endif
    );

    assign locked = state == LOCKED;

    // lock after LOCK_LEN consecutive matches; a locked mismatch pulses once and drops back to SYNC
    always_comb begin
        state_n    = state;
        run_n      = run;
        mismatch_n = 1'b0;
        err_n      = err_count;
        if (cmp_valid) begin
            if (state == SYNC) begin
                if (!match) begin
                    run_n = '0;
                end else if (run == RUN_W'(LOCK_LEN - 1)) begin
                    state_n = LOCKED;
                    run_n   = '0;
                end else begin
                    run_n = run + 1'b1;
                end
            end else if (!match) begin
                state_n    = SYNC;
                mismatch_n = 1'b1;
                err_n      = (err_count == '1) ? err_count : err_count + 1'b1;
            end
        end
    end

    // registered state, run length, pulse and saturating error count
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SYNC;
            run       <= '0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            run       <= run_n;
            mismatch  <= mismatch_n;
            err_count <= err_n;
        end
    end

`ifdef COUNT_MONITOR_WRAP_EN
    // count legal all-ones to zero rollovers, saturating
    always_ff @(posedge clk) begin
        if (reset)
            wrap_count <= '0;
        else if (cmp_valid && wrap_hit && wrap_count != '1)
            wrap_count <= wrap_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: randomized and directed checks of count_monitor against a behavioural model (wrap checks with COUNT_MONITOR_WRAP_EN)
module tb_count_monitor;

    localparam int LOCK_LEN = 4;

    logic       clk = 1'b0;
    logic       reset, dut_reset, enable;
    logic [3:0] count;
    logic       locked, mismatch, locked2, mismatch2;
    logic [7:0] err_count;
    logic [1:0] err2;
    logic [3:0] expected, expected2;
`ifdef COUNT_MONITOR_WRAP_EN
    logic [7:0] wrap_count, wrap2;
`endif

    count_monitor dut (
        .clk(clk), .reset(reset), .dut_reset(dut_reset), .enable(enable), .count(count),
        .locked(locked), .mismatch(mismatch), .err_count(err_count), .expected(expected)
`ifdef COUNT_MONITOR_WRAP_EN
        , .wrap_count(wrap_count)
`endif
    );

    count_monitor #(.ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .dut_reset(dut_reset), .enable(enable), .count(count),
        .locked(locked2), .mismatch(mismatch2), .err_count(err2), .expected(expected2)
`ifdef COUNT_MONITOR_WRAP_EN
        , .wrap_count(wrap2)
`endif
    );

    always #5 clk = ~clk;

    // reference model state
    logic [3:0] m_prev, m_exp;
    bit         m_pen, m_prst, m_hv, m_locked, m_mis;
    int         m_streak;
    logic [7:0] m_err, m_wrap;
    logic [1:0] m_err2;

    int checks = 0;
    int passes = 0;

    wire [21:0] obs  = {locked, mismatch, err_count, expected, locked2, mismatch2, err2, expected2};
    wire [21:0] want = {m_locked, m_mis, m_err, m_exp, m_locked, m_mis, m_err2, m_exp};

    task automatic step(input bit r, input bit dr, input bit en, input logic [3:0] c);
        logic [3:0] pred;
        bit ok;
        @(negedge clk);
        reset = r; dut_reset = dr; enable = en; count = c;
        @(posedge clk);
        if (r) begin
            m_prev = 0; m_pen = 0; m_prst = 0; m_hv = 0; m_locked = 0; m_mis = 0;
            m_streak = 0; m_err = 0; m_err2 = 0; m_wrap = 0;
        end else begin
            m_mis = 0;
            if (m_hv) begin
                pred = m_prst ? 4'd0 : m_pen ? 4'((m_prev + 1) % 16) : m_prev;
                ok = (c == pred);
                if (m_locked) begin
                    if (!ok) begin
                        m_mis = 1; m_locked = 0;
                        m_err = (m_err == 8'hff) ? m_err : m_err + 8'd1;
                        m_err2 = (m_err2 == 2'd3) ? m_err2 : m_err2 + 2'd1;
                    end
                end else begin
                    m_streak = ok ? m_streak + 1 : 0;
                    if (m_streak == LOCK_LEN) begin
                        m_locked = 1; m_streak = 0;
                    end
                end
                if (ok && m_pen && m_prev == 4'd15 && c == 4'd0 && m_wrap != 8'hff) m_wrap = m_wrap + 8'd1;
            end
            m_prev = c; m_pen = en; m_prst = dr; m_hv = 1;
        end
        m_exp = m_prst ? 4'd0 : m_pen ? 4'((m_prev + 1) % 16) : m_prev;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 4'(i + 3));
            checks++;
            if (obs !== want || locked !== 1'b0 || err_count !== 8'd0 || expected !== 4'd0)
                $display("FAIL reset[%0d]: got %h want %h", i, obs, want);
            else passes++;
        end
    endtask

    task automatic test_lock();
        for (int i = 0; i <= 5; i++) begin
            step(0, 0, 1, 4'(i));
            checks++;
            if (obs !== want) $display("FAIL lock[%0d]: got %h want %h", i, obs, want);
            else passes++;
            if (i == 3 || i == 4) begin
                checks++;
                if (locked !== (i == 4) || mismatch !== 1'b0 || expected !== 4'(i + 1))
                    $display("FAIL lock_point[%0d]: got locked=%b exp=%0d want locked=%b exp=%0d",
                             i, locked, expected, i == 4, i + 1);
                else passes++;
            end
        end
    endtask

    task automatic test_wrap();
        for (int v = 6; v <= 17; v++) begin
            step(0, 0, 1, 4'(v % 16));
            checks++;
            if (obs !== want || mismatch !== 1'b0 || locked !== 1'b1)
                $display("FAIL wrap[%0d]: got %h want %h", v, obs, want);
            else passes++;
        end
`ifdef COUNT_MONITOR_WRAP_EN
        checks++;
        if (wrap_count !== 8'd1 || wrap_count !== m_wrap)
            $display("FAIL wrap_count: got %0d want 1", wrap_count);
        else passes++;
`endif
    endtask

    task automatic test_hold_mismatch();
        logic [3:0] vals [13];
        vals = '{2, 3, 4, 5, 6, 7, 7, 7, 8, 9, 10, 11, 12};
        for (int i = 0; i < 13; i++) begin
            step(0, 0, vals[i] != 4'd7, vals[i]);
            checks++;
            if (obs !== want) $display("FAIL hold[%0d]: got %h want %h", i, obs, want);
            else passes++;
            if (i == 8 || i == 9 || i == 12) begin
                checks++;
                if (mismatch !== (i == 8) || locked !== (i == 12) || err_count !== 8'd1)
                    $display("FAIL hold_point[%0d]: got mis=%b locked=%b err=%0d want mis=%b locked=%b err=1",
                             i, mismatch, locked, err_count, i == 8, i == 12);
                else passes++;
            end
        end
    endtask

    task automatic test_dut_reset();
        step(0, 1, 1, 4'd13);
        step(0, 0, 1, 4'd0);
        checks++;
        if (obs !== want || mismatch !== 1'b0 || locked !== 1'b1)
            $display("FAIL dut_reset_zero: got %h want %h", obs, want);
        else passes++;
        step(0, 1, 1, 4'd1);
        step(0, 0, 1, 4'd2);
        checks++;
        if (obs !== want || mismatch !== 1'b1 || err_count !== 8'd2)
            $display("FAIL dut_reset_bad: got %h want %h", obs, want);
        else passes++;
    endtask

    task automatic test_err_sat();
        logic [1:0] sat [5];
        logic [3:0] v;
        int pulses;
        sat = '{1, 2, 3, 3, 3};
        v = 4'd3;
        pulses = 0;
        step(1, 0, 0, 4'd0);
        for (int rep = 0; rep < 5; rep++) begin
            for (int k = 0; k < 5; k++) begin
                step(0, 0, 1, v);
                v = v + 4'd1;
                pulses += int'(mismatch2);
            end
            v = v + 4'd5;
            step(0, 0, 1, v);
            v = v + 4'd1;
            pulses += int'(mismatch2);
            checks++;
            if (obs !== want || mismatch2 !== 1'b1 || err2 !== sat[rep] || err_count !== 8'(rep + 1))
                $display("FAIL err_sat[%0d]: got err2=%0d err=%0d mis2=%b want err2=%0d err=%0d mis2=1",
                         rep, err2, err_count, mismatch2, sat[rep], rep + 1);
            else passes++;
        end
        checks++;
        if (pulses !== 5) $display("FAIL err_sat_pulses: got %0d want 5", pulses);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] v;
        v = 4'd0;
        step(1, 0, 0, 4'd0);
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 5; k++) begin
                step(0, 0, 1, v);
                v = v + 4'd1;
            end
            if (rep < 2) begin
                v = v + 4'd7;
                step(0, 0, 1, v);
                v = v + 4'd1;
            end
        end
        checks++;
        if (obs !== want || locked !== 1'b1 || err_count !== 8'd2)
            $display("FAIL reset_mid_pre: got %h want %h", obs, want);
        else passes++;
        step(1, 0, 1, v);
        checks++;
        if (obs !== want || locked !== 1'b0 || err_count !== 8'd0 || expected !== 4'd0)
            $display("FAIL reset_mid_clear: got %h want %h", obs, want);
        else passes++;
        for (int k = 11; k <= 15; k++) begin
            step(0, 0, 1, 4'(k));
            checks++;
            if (obs !== want || mismatch !== 1'b0 || locked !== (k == 15))
                $display("FAIL reset_mid_relock[%0d]: got locked=%b mis=%b want locked=%b mis=0",
                         k, locked, mismatch, k == 15);
            else passes++;
        end
    endtask

    task automatic test_random();
        bit r, dr, en;
        logic [3:0] c;
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 99) == 0;
            dr = $urandom_range(0, 19) == 0;
            en = $urandom_range(0, 3) != 0;
            c  = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(0, 15)) : m_exp;
            step(r, dr, en, c);
            checks++;
            if (obs !== want) $display("FAIL random[%0d]: got %h want %h", i, obs, want);
            else passes++;
`ifdef COUNT_MONITOR_WRAP_EN
            checks++;
            if (wrap_count !== m_wrap) $display("FAIL random_wrap[%0d]: got %0d want %0d", i, wrap_count, m_wrap);
            else passes++;
`endif
        end
    endtask

    initial begin
        reset = 1'b1; dut_reset = 1'b0; enable = 1'b0; count = 4'd0;
        test_reset();
        test_lock();
        test_wrap();
        test_hold_mismatch();
        test_dut_reset();
        test_err_sat();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
